obstacle_spawner: RTL

Initiator side of the obstacle create handshake. Decides when and in which road lane the next obstacle appears, and drives `createObject`/`objectX` into the obstacle mover. Spawn spacing is counted in frames and shrinks as player speed rises. Lane choice is pseudo-random (16-bit LFSR) and never repeats the previous lane. Sits in the game controller between the speed/game-state logic and the obstacle mover instances.

---
 rtl/obstacle_spawner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paces obstacle creation in frames (interval shrinks with speed),
// picks a non-repeating lane from a 16-bit Galois LFSR and issues the create handshake.
module obstacle_spawner #(
   parameter int unsigned ROAD_LEFT_X   = 160,
   parameter int unsigned LANE_WIDTH    = 80,
   parameter int unsigned NUM_LANES     = 4,
   parameter int unsigned BASE_INTERVAL = 90,
   parameter int unsigned MIN_INTERVAL  = 30,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [4:0]  speed,
   input  logic        gameOver,
   input  logic        object_ready,
   output logic        createObject,
   output logic [10:0] objectX,
   output logic [7:0]  spawnCount
);

   localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
   localparam int unsigned X_W       = 11;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned LFSR_W    = 16;

   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

   localparam logic [1:0] IDLE_ST = 2'd0;
   localparam logic [1:0] WAIT_ST = 2'd1;
   localparam logic [1:0] PICK_ST = 2'd2;
   localparam logic [1:0] ARM_ST  = 2'd3;

   logic [1:0]           state_q,     state_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [LANE_BITS-1:0] prev_lane_q, prev_lane_d;
   logic [X_W-1:0]       objx_q,      objx_d;
   logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
   logic [LFSR_W-1:0]    lfsr_q,      lfsr_d;

   logic [CNT_W-1:0]     speed_x2;
   logic [CNT_W-1:0]     interval_raw;
   logic [CNT_W-1:0]     interval_c;
   logic [LANE_BITS-1:0] lane_raw;
   logic [LANE_BITS-1:0] lane_pick;
   logic [X_W-1:0]       lane_x;

   // Spawn interval in frames: BASE - 2*speed, clamped from below.
   always_comb begin
      speed_x2     = CNT_W'({speed, 1'b0});
      interval_raw = CNT_W'(BASE_INTERVAL) - speed_x2;
      interval_c   = (interval_raw < CNT_W'(MIN_INTERVAL)) ? CNT_W'(MIN_INTERVAL) : interval_raw;
   end

   // Lane choice: bump to the neighbouring lane if the LFSR repeats the last one.
   always_comb begin
      lane_raw  = lfsr_q[LANE_BITS-1:0];
      lane_pick = (lane_raw == prev_lane_q) ? LANE_BITS'(lane_raw + LANE_BITS'(1)) : lane_raw;
      lane_x    = X_W'(ROAD_LEFT_X) + X_W'(lane_pick) * X_W'(LANE_WIDTH);
   end

   // Mealy create strobe so the mover sees it in the same cycle it reports ready.
   assign createObject = (state_q == ARM_ST) & object_ready & ~gameOver;
   assign objectX      = objx_q;
   assign spawnCount   = spawn_cnt_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prev_lane_d = prev_lane_q;
      objx_d      = objx_q;
      spawn_cnt_d = spawn_cnt_q;
      lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : '0);

      if (gameOver) begin
         state_d = IDLE_ST;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE_ST: begin
               state_d = WAIT_ST;
               cnt_d   = interval_c;
            end
            WAIT_ST: begin
               if (startOfFrame) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = PICK_ST;
                  end
               end
            end
            PICK_ST: begin
               prev_lane_d = lane_pick;
               objx_d      = lane_x;
               state_d     = ARM_ST;
            end
            ARM_ST: begin
               if (createObject) begin
                  state_d = WAIT_ST;
                  cnt_d   = interval_c;
                  if (spawn_cnt_q != {CNT_W{1'b1}}) begin
                     spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE_ST;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE_ST;
         cnt_q       <= '0;
         prev_lane_q <= '0;
         objx_q      <= X_W'(ROAD_LEFT_X);
         spawn_cnt_q <= '0;
         lfsr_q      <= LFSR_SEED;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_lane_q <= prev_lane_d;
         objx_q      <= objx_d;
         spawn_cnt_q <= spawn_cnt_d;
         lfsr_q      <= lfsr_d;
      end
   end

endmodule
